// File: rtl/quant_pkg.sv
// Shared constants and FSM encoding for the macroblock quantizer scheduler.
package quant_pkg;
  localparam int NUM_Y         = 16;
  localparam int NUM_UV        = 8;
  localparam int TOTAL_BLK     = NUM_Y + NUM_UV;
  localparam int QUANT_LATENCY = 2;
  localparam int WAIT_TIMEOUT  = 8;

  typedef enum logic [2:0] {
    IDLE, READ, LOAD, START, HOLD, WAIT, OUT
  } state_e;
endpackage

// File: rtl/quant_blk_cnt.sv
// Block index counter with last-block compare and luma/chroma decode.
module quant_blk_cnt
  import quant_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] idx,
  output logic          last,
  output logic          is_uv
);
  always_ff @(posedge clk) begin
    if (rst || clr)  idx <= '0;
    else if (inc)    idx <= idx + AW'(1);
  end

  assign last  = (idx == AW'(TOTAL_BLK - 1));
  assign is_uv = (idx >= AW'(NUM_Y));
endmodule

// File: rtl/quant_mb_sched.sv
// Sequences the shared quantizer over 16 luma + 8 chroma blocks of a macroblock.
module quant_mb_sched
  import quant_pkg::*;
#(
  parameter int IW = 16,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mb_start,
  output logic                 mb_busy,
  output logic                 mb_done,
  output logic                 coef_rd_en,
  output logic [AW-1:0]        coef_rd_addr,
  input  logic [16*IW-1:0]     coef_rd_data,
  output logic [16*IW-1:0]     q_in,
  output logic                 mtx_sel,
  output logic                 q_start,
  input  logic                 q_done,
  input  logic                 q_nz,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [AW-1:0]        res_idx,
  output logic [TOTAL_BLK-1:0] nz_map
);
  state_e        state, state_n;
  logic [AW-1:0] idx;
  logic          last, is_uv, accept, mb_go;
  logic [3:0]    wait_cnt;
  logic          err_timeout;

  assign mb_go  = (state == IDLE) && mb_start;
  assign accept = res_valid && res_ready;

  quant_blk_cnt #(.AW(AW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (mb_go),
    .inc   (accept && !last),
    .idx   (idx),
    .last  (last),
    .is_uv (is_uv)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // res_valid rises combinationally with q_done so an immediate accept keeps 5 cycles/block.
  always_comb begin
    state_n    = state;
    coef_rd_en = 1'b0;
    q_start    = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE:  if (mb_start) state_n = READ;
      READ:  begin coef_rd_en = 1'b1; state_n = LOAD; end
      LOAD:  state_n = START;
      START: begin q_start = 1'b1; state_n = HOLD; end
      HOLD:  state_n = WAIT;
      WAIT:  if (q_done) begin res_valid = 1'b1; state_n = OUT; end
      OUT:   res_valid = 1'b1;
      default: state_n = IDLE;
    endcase
    if (res_valid && res_ready) state_n = last ? IDLE : READ;
  end

  assign mb_busy      = (state != IDLE);
  assign coef_rd_addr = coef_rd_en ? idx : '0;
  assign res_idx      = res_valid ? idx : '0;

  // q_in/mtx_sel only change in LOAD, so they stay put from START through downstream accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_in    <= '0;
      mtx_sel <= 1'b0;
      nz_map  <= '0;
      mb_done <= 1'b0;
    end else begin
      mb_done <= accept && last;
      if (state == LOAD) begin
        q_in    <= coef_rd_data;
        mtx_sel <= is_uv;
      end
      if (mb_go)                          nz_map      <= '0;
      else if (state == WAIT && q_done)   nz_map[idx] <= q_nz;
    end
  end

  // Sticky debug flag: quantizer overdue; the FSM keeps waiting regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else if (!q_done && !err_timeout) begin
      if (wait_cnt == 4'(WAIT_TIMEOUT - 1)) err_timeout <= 1'b1;
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
endmodule
